hazard_forward_ctrl: RTL and testbench

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_forward_ctrl_if.sv | 32 +++
 rtl/fwd_select.sv | 30 +++
 rtl/hazard_forward_ctrl.sv | 86 ++++++++
 tb/tb_hazard_forward_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the decode-stage hazard/forwarding controller.
// Tags describe the destination write carried by each downstream pipeline stage.
package hazard_pkg;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EX = 2'b01;
    localparam logic [1:0] SEL_DM = 2'b10;
    localparam logic [1:0] SEL_WB = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    typedef struct packed {
        logic [4:0] rw;
        logic       wr_en;
        logic       is_load;
    } tag_t;

    localparam tag_t BUBBLE = tag_t'{rw: 5'd0, wr_en: 1'b0, is_load: 1'b0};

    function automatic logic tag_hits(input tag_t t, input logic [4:0] src);
        return t.wr_en && (t.rw == src);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Decode-side request and register-bank control bundle of the hazard controller.
// The slave side is the controller; the master side is the decode stage/datapath.
interface hazard_forward_ctrl_if;

    logic       instr_valid;
    logic [4:0] RA;
    logic [4:0] RB;
    logic [4:0] RW_id;
    logic       wr_en_id;
    logic       is_load_id;
    logic       imm_sel_id;
    logic       flush;

    logic [1:0] mux_sel_A;
    logic [1:0] mux_sel_B;
    logic       imm_sel;
    logic       stall;
    logic [4:0] RW_dm;
    logic [4:0] RW_wb;
    logic       wb_en;

    modport master (
        output instr_valid, RA, RB, RW_id, wr_en_id, is_load_id, imm_sel_id, flush,
        input  mux_sel_A, mux_sel_B, imm_sel, stall, RW_dm, RW_wb, wb_en
    );

    modport slave (
        input  instr_valid, RA, RB, RW_id, wr_en_id, is_load_id, imm_sel_id, flush,
        output mux_sel_A, mux_sel_B, imm_sel, stall, RW_dm, RW_wb, wb_en
    );

endinterface

// File: rtl/fwd_select.sv
// Picks the forwarding source for one operand: the youngest stage writing the
// requested register wins, and register 0 is never forwarded.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  tag_t       ex_tag,
    input  tag_t       dm_tag,
    input  tag_t       wb_tag,
    output logic [1:0] sel
);

    // Load-ness only matters to the stall decision, not to source selection.
    logic unused_load_bits;
    assign unused_load_bits = ex_tag.is_load ^ dm_tag.is_load ^ wb_tag.is_load;

    always_comb begin
        sel = SEL_RF;
        if (src == REG_ZERO) begin
            sel = SEL_RF;
        end else if (tag_hits(ex_tag, src)) begin
            sel = SEL_EX;
        end else if (tag_hits(dm_tag, src)) begin
            sel = SEL_DM;
        end else if (tag_hits(wb_tag, src)) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller: tracks EX/DM/WB destination tags, forwards operands and
// inserts a single bubble on a load-use hazard; flush squashes the decode slot.
module hazard_forward_ctrl
    import hazard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);

    tag_t       ex_tag;
    tag_t       dm_tag;
    tag_t       wb_tag;
    tag_t       id_tag;
    state_t     state;
    logic       load_use;
    logic       stall_now;
    logic       imm_sel_q;
    logic [1:0] sel_a;
    logic [1:0] sel_b_raw;

    assign id_tag = tag_t'{rw: bus.RW_id, wr_en: bus.wr_en_id, is_load: bus.is_load_id};

    // A load in EX cannot be forwarded yet, so a consumer right behind it must wait a cycle.
    assign load_use = bus.instr_valid && ex_tag.is_load && ex_tag.wr_en &&
                      (ex_tag.rw != REG_ZERO) &&
                      ((ex_tag.rw == bus.RA) || ((ex_tag.rw == bus.RB) && !bus.imm_sel_id));

    assign stall_now = (state == RUN) && load_use && !bus.flush;

    fwd_select u_fwd_a (
        .src    (bus.RA),
        .ex_tag (ex_tag),
        .dm_tag (dm_tag),
        .wb_tag (wb_tag),
        .sel    (sel_a)
    );

    fwd_select u_fwd_b (
        .src    (bus.RB),
        .ex_tag (ex_tag),
        .dm_tag (dm_tag),
        .wb_tag (wb_tag),
        .sel    (sel_b_raw)
    );

    // Older writes keep draining to WB even while decode is stalled or squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag    <= BUBBLE;
            dm_tag    <= BUBBLE;
            wb_tag    <= BUBBLE;
            imm_sel_q <= 1'b0;
            state     <= RUN;
        end else begin
            wb_tag <= dm_tag;
            dm_tag <= ex_tag;
            if (bus.instr_valid && !stall_now && !bus.flush) begin
                ex_tag <= id_tag;
            end else begin
                ex_tag <= BUBBLE;
            end
            if (!stall_now) begin
                imm_sel_q <= bus.imm_sel_id;
            end
            if (bus.flush) begin
                state <= RUN;
            end else begin
                case (state)
                    RUN:     state <= load_use ? STALL : RUN;
                    STALL:   state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

    assign bus.mux_sel_A = sel_a;
    assign bus.mux_sel_B = bus.imm_sel_id ? SEL_RF : sel_b_raw;
    assign bus.stall     = stall_now;
    assign bus.imm_sel   = imm_sel_q;
    assign bus.RW_dm     = dm_tag.rw;
    assign bus.RW_wb     = wb_tag.rw;
    assign bus.wb_en     = wb_tag.wr_en;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scenarios for hazard_forward_ctrl; hand-derived expectations are
// queued when each decode slot is driven and compared mid-cycle.
module tb_hazard_forward_ctrl;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rw;
        logic       wr;
        logic       ld;
        logic       imm;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic       stall;
        logic       imm_sel;
        logic [4:0] rw_dm;
        logic [4:0] rw_wb;
        logic       wb_en;
    } out_t;

    typedef struct {
        string name;
        bit    chk;
        stim_t s;
        out_t  exp;
    } row_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    sb_t  sb[$];

    hazard_forward_ctrl_if bus();

    hazard_forward_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t stim(bit r, bit v, bit [4:0] ra, bit [4:0] rb, bit [4:0] rw,
                                   bit wr, bit ld, bit imm, bit fl);
        return stim_t'{rst: r, valid: v, ra: ra, rb: rb, rw: rw, wr: wr, ld: ld, imm: imm, fl: fl};
    endfunction

    function automatic stim_t nop();
        return stim(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic row_t row(string n, bit c, stim_t s, bit [1:0] a, bit [1:0] b, bit st,
                                 bit imm, bit [4:0] dm, bit [4:0] wbr, bit wb);
        row_t r;
        r.name = n;
        r.chk  = c;
        r.s    = s;
        r.exp  = out_t'{sel_a: a, sel_b: b, stall: st, imm_sel: imm, rw_dm: dm, rw_wb: wbr, wb_en: wb};
        return r;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("a=%b b=%b stall=%b imm_sel=%b RW_dm=%0d RW_wb=%0d wb_en=%b",
                         o.sel_a, o.sel_b, o.stall, o.imm_sel, o.rw_dm, o.rw_wb, o.wb_en);
    endfunction

    function automatic out_t observe();
        return {bus.mux_sel_A, bus.mux_sel_B, bus.stall, bus.imm_sel, bus.RW_dm, bus.RW_wb, bus.wb_en};
    endfunction

    task automatic drive(input stim_t s);
        rst            = s.rst;
        bus.instr_valid = s.valid;
        bus.RA         = s.ra;
        bus.RB         = s.rb;
        bus.RW_id      = s.rw;
        bus.wr_en_id   = s.wr;
        bus.is_load_id = s.ld;
        bus.imm_sel_id = s.imm;
        bus.flush      = s.fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(nop());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        row_t rows[$];
        sb_t  got;
        out_t obs;
        rows.push_back(row("reset_pre_write", 1, stim(0, 1, 0, 0, 4, 1, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("reset_assert", 0, stim(1, 1, 0, 0, 4, 1, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("reset_clear_1", 1, nop(), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("reset_clear_2", 1, nop(), 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            if (rows[i].chk) sb.push_back(sb_t'{name: rows[i].name, exp: rows[i].exp});
            @(negedge clk);
            if (rows[i].chk) begin
                got = sb.pop_front();
                obs = observe();
                checks++;
                if (obs !== got.exp) $display("[TB] FAIL %s: got %s, expected %s", got.name, fmt(obs), fmt(got.exp));
                else passes++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        sb_t  got;
        out_t obs;
        rows.push_back(row("b2b_i1", 1, stim(0, 1, 1, 2, 7, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("b2b_fwd_ex", 1, stim(0, 1, 7, 3, 8, 1, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("b2b_dm7", 1, nop(), 0, 0, 0, 0, 7, 0, 0));
        rows.push_back(row("b2b_wb7", 1, nop(), 0, 0, 0, 0, 8, 7, 1));
        rows.push_back(row("b2b_wb8", 1, nop(), 0, 0, 0, 0, 0, 8, 1));
        foreach (rows[i]) begin
            drive(rows[i].s);
            if (rows[i].chk) sb.push_back(sb_t'{name: rows[i].name, exp: rows[i].exp});
            @(negedge clk);
            if (rows[i].chk) begin
                got = sb.pop_front();
                obs = observe();
                checks++;
                if (obs !== got.exp) $display("[TB] FAIL %s: got %s, expected %s", got.name, fmt(obs), fmt(got.exp));
                else passes++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_distance();
        row_t rows[$];
        sb_t  got;
        out_t obs;
        rows.push_back(row("dist_write_r5", 1, stim(0, 1, 0, 0, 5, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("dist_1_ex", 1, stim(0, 1, 5, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("dist_2_dm", 1, stim(0, 1, 5, 5, 0, 0, 0, 0, 0), 2, 2, 0, 0, 5, 0, 0));
        rows.push_back(row("dist_3_wb", 1, stim(0, 1, 0, 5, 0, 0, 0, 0, 0), 0, 3, 0, 0, 0, 5, 1));
        rows.push_back(row("dist_4_rf", 1, stim(0, 1, 5, 5, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            if (rows[i].chk) sb.push_back(sb_t'{name: rows[i].name, exp: rows[i].exp});
            @(negedge clk);
            if (rows[i].chk) begin
                got = sb.pop_front();
                obs = observe();
                checks++;
                if (obs !== got.exp) $display("[TB] FAIL %s: got %s, expected %s", got.name, fmt(obs), fmt(got.exp));
                else passes++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        sb_t  got;
        out_t obs;
        // RB consumer: one bubble, then the load is picked up from DM.
        rows.push_back(row("lu_load_r6", 1, stim(0, 1, 0, 0, 6, 1, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("lu_stall", 1, stim(0, 1, 1, 6, 9, 1, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0));
        rows.push_back(row("lu_fwd_dm", 1, stim(0, 1, 1, 6, 9, 1, 0, 0, 0), 0, 2, 0, 0, 6, 0, 0));
        rows.push_back(row("lu_load_wb", 1, nop(), 0, 0, 0, 0, 0, 6, 1));
        rows.push_back(row("lu_idle_a", 0, nop(), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("lu_idle_b", 0, nop(), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("lu_idle_c", 0, nop(), 0, 0, 0, 0, 0, 0, 0));
        // Immediate operand B hides the RB dependency.
        rows.push_back(row("lu_imm_load", 1, stim(0, 1, 0, 0, 6, 1, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("lu_imm_nostall", 1, stim(0, 1, 0, 6, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("lu_imm_reg", 1, nop(), 0, 0, 0, 1, 6, 0, 0));
        rows.push_back(row("lu_imm_clear", 1, nop(), 0, 0, 0, 0, 0, 6, 1));
        rows.push_back(row("lu_idle_d", 0, nop(), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("lu_idle_e", 0, nop(), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("lu_idle_f", 0, nop(), 0, 0, 0, 0, 0, 0, 0));
        // RA consumer with immediate: stalls, and imm_sel holds through the stall.
        rows.push_back(row("lu_ra_load", 1, stim(0, 1, 0, 0, 6, 1, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("lu_ra_stall", 1, stim(0, 1, 6, 0, 0, 0, 0, 1, 0), 1, 0, 1, 0, 0, 0, 0));
        rows.push_back(row("lu_ra_hold_imm", 1, stim(0, 1, 6, 0, 0, 0, 0, 1, 0), 2, 0, 0, 0, 6, 0, 0));
        rows.push_back(row("lu_ra_imm_reg", 1, nop(), 0, 0, 0, 1, 0, 6, 1));
        foreach (rows[i]) begin
            drive(rows[i].s);
            if (rows[i].chk) sb.push_back(sb_t'{name: rows[i].name, exp: rows[i].exp});
            @(negedge clk);
            if (rows[i].chk) begin
                got = sb.pop_front();
                obs = observe();
                checks++;
                if (obs !== got.exp) $display("[TB] FAIL %s: got %s, expected %s", got.name, fmt(obs), fmt(got.exp));
                else passes++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_priority_r0();
        row_t rows[$];
        sb_t  got;
        out_t obs;
        rows.push_back(row("prio_write_r3a", 1, stim(0, 1, 0, 0, 3, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("prio_write_r3b", 1, stim(0, 1, 3, 0, 3, 1, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("prio_ex_over_dm", 1, stim(0, 1, 3, 3, 0, 0, 0, 0, 0), 1, 1, 0, 0, 3, 0, 0));
        rows.push_back(row("prio_dm_over_wb", 1, stim(0, 1, 3, 0, 0, 1, 0, 0, 0), 2, 0, 0, 0, 3, 3, 1));
        rows.push_back(row("prio_r0_never", 1, stim(0, 1, 0, 3, 0, 0, 0, 0, 0), 0, 3, 0, 0, 0, 3, 1));
        foreach (rows[i]) begin
            drive(rows[i].s);
            if (rows[i].chk) sb.push_back(sb_t'{name: rows[i].name, exp: rows[i].exp});
            @(negedge clk);
            if (rows[i].chk) begin
                got = sb.pop_front();
                obs = observe();
                checks++;
                if (obs !== got.exp) $display("[TB] FAIL %s: got %s, expected %s", got.name, fmt(obs), fmt(got.exp));
                else passes++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        sb_t  got;
        out_t obs;
        rows.push_back(row("flush_load_r6", 1, stim(0, 1, 0, 0, 6, 1, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("flush_no_stall", 1, stim(0, 1, 0, 6, 9, 1, 0, 0, 1), 0, 1, 0, 0, 0, 0, 0));
        rows.push_back(row("flush_load_dm", 1, nop(), 0, 0, 0, 0, 6, 0, 0));
        rows.push_back(row("flush_load_wb", 1, nop(), 0, 0, 0, 0, 0, 6, 1));
        rows.push_back(row("flush_bubble_wb", 1, nop(), 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            if (rows[i].chk) sb.push_back(sb_t'{name: rows[i].name, exp: rows[i].exp});
            @(negedge clk);
            if (rows[i].chk) begin
                got = sb.pop_front();
                obs = observe();
                checks++;
                if (obs !== got.exp) $display("[TB] FAIL %s: got %s, expected %s", got.name, fmt(obs), fmt(got.exp));
                else passes++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        row_t rows[$];
        sb_t  got;
        out_t obs;
        rows.push_back(row("rst_stall_load", 1, stim(0, 1, 0, 0, 6, 1, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("rst_stall_hit", 1, stim(0, 1, 0, 6, 9, 1, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0));
        rows.push_back(row("rst_stall_assert", 0, stim(1, 1, 0, 6, 9, 1, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("rst_stall_clear", 1, stim(0, 1, 0, 6, 9, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(row("rst_stall_no_wb", 1, nop(), 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            if (rows[i].chk) sb.push_back(sb_t'{name: rows[i].name, exp: rows[i].exp});
            @(negedge clk);
            if (rows[i].chk) begin
                got = sb.pop_front();
                obs = observe();
                checks++;
                if (obs !== got.exp) $display("[TB] FAIL %s: got %s, expected %s", got.name, fmt(obs), fmt(got.exp));
                else passes++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        passes = 0;
        drive(stim(1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        idle(3);
        test_back_to_back();
        idle(3);
        test_distance();
        idle(3);
        test_load_use();
        idle(3);
        test_priority_r0();
        idle(3);
        test_flush();
        idle(3);
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
